// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite initiator: turns one cmd request into an AW/W/B or AR/R
// transaction and presents the B/R result on a registered response port.
module axil_cmd_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_we,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic [AXI_ADDR_WIDTH-1:0]   m_aw_addr,
  output logic [2:0]                  m_aw_prot,
  output logic                        m_aw_valid,
  input  logic                        m_aw_ready,
  output logic [AXI_DATA_WIDTH-1:0]   m_w_data,
  output logic [AXI_DATA_WIDTH/8-1:0] m_w_strb,
  output logic                        m_w_valid,
  input  logic                        m_w_ready,
  input  logic [1:0]                  m_b_resp,
  input  logic                        m_b_valid,
  output logic                        m_b_ready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_ar_addr,
  output logic [2:0]                  m_ar_prot,
  output logic                        m_ar_valid,
  input  logic                        m_ar_ready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_r_data,
  input  logic [1:0]                  m_r_resp,
  input  logic                        m_r_valid,
  output logic                        m_r_ready
);

  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  // Every channel transfers on a rising edge where valid and ready are both high; a
  // raised valid keeps itself and its payload until that edge and never looks at ready.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WADDR = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RSP   = 3'd5
  } state_t;

  state_t                    state, state_nx;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_nx;
  logic [AXI_DATA_WIDTH-1:0] wdata_q, wdata_nx;
  logic [STRB_W-1:0]         wstrb_q, wstrb_nx;
  logic                      aw_valid_q, aw_valid_nx;
  logic                      w_valid_q, w_valid_nx;
  logic                      ar_valid_q, ar_valid_nx;
  logic                      b_ready_q, b_ready_nx;
  logic                      r_ready_q, r_ready_nx;
  logic                      rsp_valid_q, rsp_valid_nx;
  logic [AXI_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_nx;
  logic [1:0]                rsp_resp_q, rsp_resp_nx;
  logic                      aw_done, w_done;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      b_ready_q   <= 1'b0;
      r_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state       <= state_nx;
      addr_q      <= addr_nx;
      wdata_q     <= wdata_nx;
      wstrb_q     <= wstrb_nx;
      aw_valid_q  <= aw_valid_nx;
      w_valid_q   <= w_valid_nx;
      ar_valid_q  <= ar_valid_nx;
      b_ready_q   <= b_ready_nx;
      r_ready_q   <= r_ready_nx;
      rsp_valid_q <= rsp_valid_nx;
      rsp_rdata_q <= rsp_rdata_nx;
      rsp_resp_q  <= rsp_resp_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    addr_nx      = addr_q;
    wdata_nx     = wdata_q;
    wstrb_nx     = wstrb_q;
    aw_valid_nx  = aw_valid_q;
    w_valid_nx   = w_valid_q;
    ar_valid_nx  = ar_valid_q;
    b_ready_nx   = b_ready_q;
    r_ready_nx   = r_ready_q;
    rsp_valid_nx = rsp_valid_q;
    rsp_rdata_nx = rsp_rdata_q;
    rsp_resp_nx  = rsp_resp_q;
    aw_done      = 1'b0;
    w_done       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_nx  = cmd_addr;
          wdata_nx = cmd_wdata;
          wstrb_nx = cmd_wstrb;
          if (cmd_we) begin
            state_nx    = WADDR;
            aw_valid_nx = 1'b1;
            w_valid_nx  = 1'b1;
          end else begin
            state_nx    = RADDR;
            ar_valid_nx = 1'b1;
          end
        end
      end
      WADDR: begin
        // A channel whose valid is already low in WADDR finished its handshake earlier.
        aw_done = !aw_valid_q || m_aw_ready;
        w_done  = !w_valid_q || m_w_ready;
        if (aw_valid_q && m_aw_ready) aw_valid_nx = 1'b0;
        if (w_valid_q && m_w_ready)   w_valid_nx  = 1'b0;
        if (aw_done && w_done) begin
          state_nx   = WRESP;
          b_ready_nx = 1'b1;
        end
      end
      WRESP: begin
        if (m_b_valid) begin
          b_ready_nx   = 1'b0;
          rsp_resp_nx  = m_b_resp;
          rsp_rdata_nx = '0;
          rsp_valid_nx = 1'b1;
          state_nx     = RSP;
        end
      end
      RADDR: begin
        if (m_ar_ready) begin
          ar_valid_nx = 1'b0;
          r_ready_nx  = 1'b1;
          state_nx    = RDATA;
        end
      end
      RDATA: begin
        if (m_r_valid) begin
          r_ready_nx   = 1'b0;
          rsp_rdata_nx = m_r_data;
          rsp_resp_nx  = m_r_resp;
          rsp_valid_nx = 1'b1;
          state_nx     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_nx = 1'b0;
          state_nx     = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign cmd_ready  = (state == IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_resp   = rsp_resp_q;
  assign m_aw_addr  = addr_q;
  assign m_aw_prot  = 3'b000;
  assign m_aw_valid = aw_valid_q;
  assign m_w_data   = wdata_q;
  assign m_w_strb   = wstrb_q;
  assign m_w_valid  = w_valid_q;
  assign m_b_ready  = b_ready_q;
  assign m_ar_addr  = addr_q;
  assign m_ar_prot  = 3'b000;
  assign m_ar_valid = ar_valid_q;
  assign m_r_ready  = r_ready_q;

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: a delay-configurable AXI-Lite slave with its own memory,
// a command-level memory model for expected read data, and directed plus random traffic.
module tb_axil_cmd_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_aw_addr, m_ar_addr;
  logic [2:0]    m_aw_prot, m_ar_prot;
  logic          m_aw_valid, m_aw_ready, m_w_valid, m_w_ready;
  logic [DW-1:0] m_w_data, m_r_data;
  logic [3:0]    m_w_strb;
  logic [1:0]    m_b_resp, m_r_resp;
  logic          m_b_valid, m_b_ready, m_ar_valid, m_ar_ready, m_r_valid, m_r_ready;

  axil_cmd_master #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot), .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_w_data(m_w_data), .m_w_strb(m_w_strb), .m_w_valid(m_w_valid), .m_w_ready(m_w_ready),
    .m_b_resp(m_b_resp), .m_b_valid(m_b_valid), .m_b_ready(m_b_ready),
    .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot), .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_data(m_r_data), .m_r_resp(m_r_resp), .m_r_valid(m_r_valid), .m_r_ready(m_r_ready)
  );

  // clock
  always #5 aclk = ~aclk;

  // slave configuration, written only by the main sequence
  int       aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0] b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  logic     stray_b = 1'b0;

  // slave state, written only by the slave process
  logic [DW-1:0] slave_mem [16];
  int       aw_wait, w_wait, ar_wait, b_wait, r_wait;
  int       aw_len, w_len, ar_len;
  int       proto_err = 0;
  logic [AW-1:0] wr_addr, rd_addr, aw_prev, ar_prev;
  logic [DW-1:0] wr_data, w_prev_data;
  logic [3:0]    wr_strb, w_prev_strb;
  logic          aw_pend, w_pend, ar_pend;

  initial begin
    for (int i = 0; i < 16; i++) slave_mem[i] = '0;
  end

  // slave: drives its inputs on the falling edge, watches master-side stability rules
  always @(negedge aclk) begin
    if (!aresetn) begin
      m_aw_ready = 0; m_w_ready = 0; m_ar_ready = 0; m_r_valid = 0;
      m_b_valid = stray_b; m_b_resp = 2'($urandom); m_r_data = $urandom; m_r_resp = 2'($urandom);
      aw_wait = 0; w_wait = 0; ar_wait = 0; b_wait = 0; r_wait = 0;
      aw_pend = 0; w_pend = 0; ar_pend = 0;
    end else begin
      if (aw_pend && (!m_aw_valid || m_aw_addr !== aw_prev)) proto_err++;
      if (w_pend && (!m_w_valid || m_w_data !== w_prev_data || m_w_strb !== w_prev_strb)) proto_err++;
      if (ar_pend && (!m_ar_valid || m_ar_addr !== ar_prev)) proto_err++;
      if (m_aw_valid && m_aw_prot !== 3'b000) proto_err++;
      if (m_ar_valid && m_ar_prot !== 3'b000) proto_err++;
      if (m_b_ready && (m_aw_valid || m_w_valid || m_ar_valid || m_r_ready || rsp_valid)) proto_err++;
      if (m_r_ready && (m_aw_valid || m_w_valid || m_ar_valid || m_b_ready || rsp_valid)) proto_err++;

      m_aw_ready = 0;
      if (m_aw_valid) begin
        if (aw_wait >= aw_delay) begin
          m_aw_ready = 1; aw_len = aw_wait + 1; wr_addr = m_aw_addr; aw_wait = 0;
        end else aw_wait++;
      end
      aw_pend = m_aw_valid && !m_aw_ready; aw_prev = m_aw_addr;

      m_w_ready = 0;
      if (m_w_valid) begin
        if (w_wait >= w_delay) begin
          m_w_ready = 1; w_len = w_wait + 1; wr_data = m_w_data; wr_strb = m_w_strb; w_wait = 0;
        end else w_wait++;
      end
      w_pend = m_w_valid && !m_w_ready; w_prev_data = m_w_data; w_prev_strb = m_w_strb;

      m_ar_ready = 0;
      if (m_ar_valid) begin
        if (ar_wait >= ar_delay) begin
          m_ar_ready = 1; ar_len = ar_wait + 1; rd_addr = m_ar_addr; ar_wait = 0;
        end else ar_wait++;
      end
      ar_pend = m_ar_valid && !m_ar_ready; ar_prev = m_ar_addr;

      m_b_valid = stray_b; m_b_resp = 2'($urandom);
      if (m_b_ready) begin
        if (b_wait >= b_delay) begin
          m_b_valid = 1; m_b_resp = b_resp_cfg; b_wait = 0;
          for (int k = 0; k < 4; k++)
            if (wr_strb[k]) slave_mem[wr_addr[5:2]][8*k +: 8] = wr_data[8*k +: 8];
        end else b_wait++;
      end

      m_r_valid = 0; m_r_data = $urandom; m_r_resp = 2'($urandom);
      if (m_r_ready) begin
        if (r_wait >= r_delay) begin
          m_r_valid = 1; m_r_data = slave_mem[rd_addr[5:2]]; m_r_resp = r_resp_cfg; r_wait = 0;
        end else r_wait++;
      end
    end
  end

  // scoreboard
  int            n_pass = 0, n_total = 0;
  logic [DW-1:0] model_mem [16];
  logic [DW-1:0] exp_q [$];
  time           last_hs;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic model_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [3:0] strb);
    for (int k = 0; k < 4; k++)
      if (strb[k]) model_mem[addr[5:2]][8*k +: 8] = data[8*k +: 8];
  endtask

  // driver: issue one command from a falling edge, return the response and its latency
  task automatic do_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [3:0] strb, input int hold,
                        output logic [DW-1:0] rdata, output logic [1:0] resp, output int lat);
    int t;
    cmd_valid = 1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata; cmd_wstrb = strb;
    rsp_ready = (hold == 0);
    rdata = 'x; resp = 'x; lat = -1;
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge aclk); t++; end
    check("cmd_ready_seen", cmd_ready, 1);
    if (!cmd_ready) begin cmd_valid = 0; return; end
    @(posedge aclk);
    last_hs = $time;
    @(negedge aclk);
    cmd_valid = 0; cmd_we = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
    check("n1_aw_valid", m_aw_valid, we);
    check("n1_w_valid", m_w_valid, we);
    check("n1_ar_valid", m_ar_valid, !we);
    if (we) begin
      check("aw_addr", m_aw_addr, addr);
      check("w_data", m_w_data, wdata);
      check("w_strb", m_w_strb, strb);
    end else check("ar_addr", m_ar_addr, addr);
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge aclk); lat++; end
    check("rsp_seen", rsp_valid, 1);
    if (!rsp_valid) return;
    rdata = rsp_rdata; resp = rsp_resp;
    for (int i = 0; i < hold; i++) begin
      check("hold_rsp_valid", rsp_valid, 1);
      check("hold_cmd_ready", cmd_ready, 0);
      check("hold_rdata", rsp_rdata, rdata);
      check("hold_resp", rsp_resp, resp);
      @(negedge aclk);
    end
    rsp_ready = 1;
    @(negedge aclk);
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd, wd;
    logic [AW-1:0] a;
    logic [3:0]    st;
    logic [1:0]    rs, er;
    logic          we;
    int            lat, hold, t;
    time           hs1;

    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    aresetn = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 0;

    // reset state
    repeat (3) @(negedge aclk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_valids", {m_aw_valid, m_w_valid, m_ar_valid, rsp_valid}, 0);
    check("rst_readys", {m_b_ready, m_r_ready}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_resp", rsp_resp, 0);
    aresetn = 1;
    @(negedge aclk);

    // minimum-latency write, then back-to-back write for throughput
    do_cmd(1, 32'h8, 32'h3, 4'hF, 0, rd, rs, lat);
    model_write(32'h8, 32'h3, 4'hF);
    hs1 = last_hs;
    check("w_fast_lat", lat, 3);
    check("w_fast_resp", rs, 0);
    check("w_fast_rdata", rd, 0);
    do_cmd(1, 32'h0, 32'h5, 4'hF, 0, rd, rs, lat);
    model_write(32'h0, 32'h5, 4'hF);
    check("throughput_ns", last_hs - hs1, 40);

    // read with 3-cycle AR ready delay
    ar_delay = 3;
    do_cmd(0, 32'h0, 32'h0, 4'h0, 0, rd, rs, lat);
    ar_delay = 0;
    check("r_delay_rdata", rd, 32'h5);
    check("r_delay_lat", lat, 6);
    check("r_delay_ar_len", ar_len, 4);
    check("r_delay_resp", rs, 0);

    // W accepted two cycles before AW
    aw_delay = 2; w_delay = 0;
    do_cmd(1, 32'h4, 32'hA5A5_1234, 4'b0101, 0, rd, rs, lat);
    model_write(32'h4, 32'hA5A5_1234, 4'b0101);
    aw_delay = 0;
    check("w_split_lat", lat, 5);
    check("w_split_aw_len", aw_len, 3);
    check("w_split_w_len", w_len, 1);
    do_cmd(0, 32'h4, 32'h0, 4'h0, 0, rd, rs, lat);
    check("w_split_readback", rd, model_mem[1]);

    // SLVERR read held by a slow consumer
    r_resp_cfg = 2'b10;
    do_cmd(0, 32'h8, 32'h0, 4'h0, 4, rd, rs, lat);
    r_resp_cfg = 2'b00;
    check("slverr_resp", rs, 2'b10);
    check("slverr_rdata", rd, model_mem[2]);

    // reset while waiting for B, with a stray B afterwards
    b_delay = 20;
    cmd_valid = 1; cmd_we = 1; cmd_addr = 32'h10; cmd_wdata = 32'hDEAD_BEEF; cmd_wstrb = 4'hF;
    @(negedge aclk);
    cmd_valid = 0;
    t = 0;
    while (!m_b_ready && t < 20) begin @(negedge aclk); t++; end
    check("wresp_reached", m_b_ready, 1);
    #2 aresetn = 0;
    #1;
    check("arst_valids", {m_aw_valid, m_w_valid, m_ar_valid, rsp_valid}, 0);
    check("arst_readys", {m_b_ready, m_r_ready}, 0);
    check("arst_cmd_ready", cmd_ready, 1);
    stray_b = 1;
    repeat (2) @(negedge aclk);
    #2 aresetn = 1;
    b_delay = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      check("stray_b_ready", m_b_ready, 0);
      check("stray_rsp_valid", rsp_valid, 0);
      check("stray_cmd_ready", cmd_ready, 1);
    end
    stray_b = 0;
    @(negedge aclk);
    do_cmd(0, 32'h10, 32'h0, 4'h0, 0, rd, rs, lat);
    check("abandoned_write", rd, model_mem[4]);

    // random traffic against the memory model
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom);
      a  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
      wd = $urandom;
      st = 4'($urandom);
      aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3); r_delay = $urandom_range(0, 3);
      b_resp_cfg = 2'($urandom); r_resp_cfg = 2'($urandom);
      hold = $urandom_range(0, 2);
      if (we) begin
        exp_q.push_back('0);
        er = b_resp_cfg;
        model_write(a, wd, st);
      end else begin
        exp_q.push_back(model_mem[a[5:2]]);
        er = r_resp_cfg;
      end
      do_cmd(we, a, wd, st, hold, rd, rs, lat);
      check("rnd_rdata", rd, exp_q.pop_front());
      check("rnd_resp", rs, er);
      check("rnd_lat", lat, we ? 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay
                               : 3 + ar_delay + r_delay);
    end

    check("protocol_errors", proto_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/axil_cmd_master.md
AXIL_CMD_MASTER -- requirements
Module: axil_cmd_master

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, data width; strobe width is AXI_DATA_WIDTH/8.
REQ-003 SHALL have ports (name  direction  width  meaning):
- aclk  in  1  single clock; all logic on rising edge.
- aresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_ADDR_WIDTH  target address.
- cmd_wdata  in  AXI_DATA_WIDTH  write data.
- cmd_wstrb  in  AXI_DATA_WIDTH/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high with rsp_valid.
- rsp_rdata  out  AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  AXI B/R response code.
- m_aw_addr, m_aw_prot, m_aw_valid  out  AW/3/1  write address channel; m_aw_ready  in  1.
- m_w_data, m_w_strb, m_w_valid  out  DW/DW/8/1  write data channel; m_w_ready  in  1.
- m_b_resp, m_b_valid  in  2/1  write response; m_b_ready  out  1.
- m_ar_addr, m_ar_prot, m_ar_valid  out  AW/3/1  read address channel; m_ar_ready  in  1.
- m_r_data, m_r_resp, m_r_valid  in  DW/2/1  read data; m_r_ready  out  1.

Function
REQ-004 SHALL be an AXI-Lite initiator with at most one transaction outstanding.
REQ-005 SHALL implement states IDLE, WADDR (AW and/or W pending), WRESP, RADDR, RDATA, RSP.
REQ-006 cmd_ready SHALL be 1 only in IDLE; all other outputs SHALL be driven from registers.
REQ-007 On cmd handshake in cycle N, SHALL capture cmd_addr/wdata/wstrb; cmd_we=1 -> WADDR with m_aw_valid=m_w_valid=1 from N+1; cmd_we=0 -> RADDR with m_ar_valid=1 from N+1.
REQ-008 In WADDR, m_aw_valid and m_w_valid SHALL each clear the cycle after its own handshake, independently of the other; when both have handshaken (same or different cycles), SHALL enter WRESP.
REQ-009 In WRESP, m_b_ready SHALL be 1; on B handshake SHALL capture m_b_resp to rsp_resp, set rsp_rdata=0, enter RSP.
REQ-010 In RADDR, on AR handshake SHALL clear m_ar_valid and enter RDATA with m_r_ready=1; on R handshake SHALL capture m_r_data/m_r_resp, enter RSP.
REQ-011 In RSP, rsp_valid SHALL be 1 with stable rsp_rdata/rsp_resp until rsp_ready; on handshake SHALL return to IDLE; next command accepted no earlier than the following cycle.
REQ-012 Any asserted m_*_valid SHALL hold value and payload stable until its handshake; valid SHALL never depend combinationally on ready.
REQ-013 m_aw_prot and m_ar_prot SHALL be 3'b000; m_aw_addr/m_ar_addr SHALL equal the captured cmd_addr.
REQ-014 m_b_valid/m_r_valid arriving outside WRESP/RDATA SHALL be ignored (ready held 0); SLVERR/DECERR SHALL be passed through unmodified, not retried.
REQ-015 Minimum latency with always-ready slave and rsp_ready=1: write rsp_valid at N+3, read rsp_valid at N+3; throughput one transaction per 4 cycles.

Reset
REQ-016 aresetn low SHALL asynchronously force IDLE, cmd_ready=1, all m_*_valid/m_*_ready=0, rsp_valid=0, rsp_rdata=0, rsp_resp=0; any in-flight transaction SHALL be abandoned without response.

Verification
REQ-017 Write 0x0000_0008 data 0x0000_0003 strb 0xF, slave always ready, b_resp=0 -> AW/W valid at N+1, rsp_valid at N+3 with rsp_resp=0, rsp_rdata=0.
REQ-018 Read 0x0000_0000, slave returns r_data 0x0000_0005 after 3-cycle ar_ready delay -> m_ar_valid/addr stable for all 3 cycles, rsp_rdata=0x0000_0005.
REQ-019 Write with m_w_ready 2 cycles before m_aw_ready -> m_w_valid drops first, m_aw_valid holds, WRESP entered only after AW handshake.
REQ-020 Read with r_resp=2'b10 and rsp_ready low 4 cycles -> rsp_valid held 4 cycles, rsp_resp=2'b10, cmd_ready=0 throughout.
REQ-021 aresetn asserted while in WRESP -> same cycle all valids/readys 0, cmd_ready=1 after release; stray m_b_valid ignored.
